servo_ramp: RTL

Slew-rate controller for the servo pulse peripheral. Software programs a target position, step size and update rate. The block then walks the servo position register toward the target, issuing one 8-bit bus write per update tick through a bus-master port arbitrated against the CPU. It sits on the peripheral bus as a slave (configuration) and as a master (servo register writes).

---
 rtl/servo_ramp.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate controller for the servo pulse peripheral.
// Walks the servo position register toward a programmed target, one bounded
// step per move tick, issuing each new position as a single master-port write.
module servo_ramp #(
    parameter logic [7:0] BASE_ADDRESS  = 8'h00,
    parameter logic [7:0] SERVO_ADDRESS = 8'h00,
    parameter int         PRESCALE      = 95
) (
    input  logic       clk,
    input  logic       rst_n,
    // configuration slave
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    // servo register master
    output logic       m_req,
    input  logic       m_gnt,
    output logic [7:0] m_address,
    output logic [7:0] m_dout,
    output logic       m_w_en
);

    // Register offsets inside the slave window.
    localparam logic [7:0] OFF_CTRL    = 8'd0;
    localparam logic [7:0] OFF_TARGET  = 8'd1;
    localparam logic [7:0] OFF_STEP    = 8'd2;
    localparam logic [7:0] OFF_RATE    = 8'd3;
    localparam logic [7:0] OFF_CURRENT = 8'd4;
    localparam logic [7:0] WINDOW_SIZE = 8'd5;

    // Last prescaler count before the wrap.
    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       enable_q,   enable_d;
    logic       done_q,     done_d;
    logic [7:0] target_q,   target_d;
    logic [7:0] step_q,     step_d;
    logic [7:0] rate_q,     rate_d;
    logic [7:0] current_q,  current_d;

    logic [7:0] pre_cnt_q,  pre_cnt_d;
    logic [7:0] rate_cnt_q, rate_cnt_d;

    state_t     state_q,    state_d;
    logic [7:0] next_pos_q, next_pos_d;

    logic [7:0] dout_q,      dout_d;
    logic [7:0] m_address_q, m_address_d;
    logic [7:0] m_dout_q,    m_dout_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [7:0] offset;
    logic       in_window;
    logic       wr_ctrl;
    logic       wr_target;
    logic       wr_step;
    logic       wr_rate;
    logic       wr_current;

    logic       pre_tick;
    logic       move_tick;

    logic       move_up;
    logic [8:0] diff;
    logic [7:0] next_calc;

    logic       commit;
    logic       busy;

    // Only enable and done-clear are taken from a CTRL write; other bits
    // are folded here so they are visibly consumed.
    logic       unused_din;
    assign unused_din = ^{din[7:3], din[1]};

    // Slave address decode relative to the window base.
    assign offset     = address - BASE_ADDRESS;
    assign in_window  = (offset < WINDOW_SIZE);
    assign wr_ctrl    = w_en && (offset == OFF_CTRL);
    assign wr_target  = w_en && (offset == OFF_TARGET);
    assign wr_step    = w_en && (offset == OFF_STEP);
    assign wr_rate    = w_en && (offset == OFF_RATE);
    assign wr_current = w_en && (offset == OFF_CURRENT);

    // Ticks. The >= on the rate compare keeps the counter from running away
    // if RATE is lowered below the current count.
    assign pre_tick  = enable_q && (pre_cnt_q == PRE_MAX);
    assign move_tick = pre_tick && (rate_cnt_q >= rate_q);

    // Position update happens on the single WRITE cycle.
    assign commit = (state_q == WRITE);

    assign busy = (state_q != IDLE) || (enable_q && (current_q != target_q));

    assign dout      = dout_q;
    assign m_address = m_address_q;
    assign m_dout    = m_dout_q;
    assign m_req     = (state_q != IDLE);
    assign m_w_en    = (state_q == WRITE);

    // Next position: clamp onto the target when within one step (or when
    // STEP is zero), otherwise move one step toward it. The 9-bit distance
    // guarantees the step never overshoots or wraps.
    always_comb begin
        move_up   = (target_q > current_q);
        diff      = move_up ? ({1'b0, target_q} - {1'b0, current_q})
                            : ({1'b0, current_q} - {1'b0, target_q});
        next_calc = target_q;
        if ((step_q != 8'd0) && (diff > {1'b0, step_q})) begin
            next_calc = move_up ? (current_q + step_q) : (current_q - step_q);
        end
    end

    // Prescaler and rate counter; both are parked at zero while disabled.
    always_comb begin
        pre_cnt_d  = pre_cnt_q;
        rate_cnt_d = rate_cnt_q;
        if (!enable_q) begin
            pre_cnt_d  = 8'd0;
            rate_cnt_d = 8'd0;
        end else if (pre_tick) begin
            pre_cnt_d  = 8'd0;
            rate_cnt_d = move_tick ? 8'd0 : (rate_cnt_q + 8'd1);
        end else begin
            pre_cnt_d  = pre_cnt_q + 8'd1;
        end
    end

    // Sequencer next state: latch a position on a tick, wait for the grant,
    // then spend exactly one cycle writing it. Ticks outside IDLE are dropped.
    always_comb begin
        state_d     = state_q;
        next_pos_d  = next_pos_q;
        m_address_d = m_address_q;
        m_dout_d    = m_dout_q;
        case (state_q)
            IDLE: begin
                if (move_tick && (current_q != target_q)) begin
                    next_pos_d = next_calc;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // Disabling abandons the pending move before any write.
                if (!enable_q) begin
                    state_d = IDLE;
                end else if (m_gnt) begin
                    state_d     = WRITE;
                    m_address_d = SERVO_ADDRESS;
                    m_dout_d    = next_pos_q;
                end
            end
            WRITE: begin
                // Always completes, regardless of enable.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register file updates; hardware position commit and done-set take
    // precedence over a coincident slave write.
    always_comb begin
        enable_d  = enable_q;
        done_d    = done_q;
        target_d  = target_q;
        step_d    = step_q;
        rate_d    = rate_q;
        current_d = current_q;

        if (wr_ctrl) begin
            enable_d = din[0];
            if (din[2]) begin
                done_d = 1'b0;
            end
        end
        if (wr_target) begin
            target_d = din;
        end
        if (wr_step) begin
            step_d = din;
        end
        if (wr_rate) begin
            rate_d = din;
        end
        // CURRENT is software-owned only while the ramp is stopped.
        if (wr_current && !enable_q) begin
            current_d = din;
        end
        if (commit) begin
            current_d = next_pos_q;
            if (next_pos_q == target_q) begin
                done_d = 1'b1;
            end
        end
    end

    // Slave read mux; zero outside the window or when not reading.
    always_comb begin
        dout_d = 8'd0;
        if (r_en && in_window) begin
            case (offset)
                OFF_CTRL:    dout_d = {5'd0, done_q, busy, enable_q};
                OFF_TARGET:  dout_d = target_q;
                OFF_STEP:    dout_d = step_q;
                OFF_RATE:    dout_d = rate_q;
                OFF_CURRENT: dout_d = current_q;
                default:     dout_d = 8'd0;
            endcase
        end
    end

    // Configuration and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
            target_q  <= 8'd0;
            step_q    <= 8'd1;
            rate_q    <= 8'd0;
            current_q <= 8'd0;
        end else begin
            enable_q  <= enable_d;
            done_q    <= done_d;
            target_q  <= target_d;
            step_q    <= step_d;
            rate_q    <= rate_d;
            current_q <= current_d;
        end
    end

    // Timebase counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q  <= 8'd0;
            rate_cnt_q <= 8'd0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            rate_cnt_q <= rate_cnt_d;
        end
    end

    // Sequencer state and latched position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            next_pos_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            next_pos_q <= next_pos_d;
        end
    end

    // Registered bus outputs; master address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= 8'd0;
            m_address_q <= 8'd0;
            m_dout_q    <= 8'd0;
        end else begin
            dout_q      <= dout_d;
            m_address_q <= m_address_d;
            m_dout_q    <= m_dout_d;
        end
    end

endmodule
